// File: rtl/up_arbiter_if.sv
// Bundle between two up-bus requesters, the arbiter and the shared up register slave.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface up_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32
) ();
    localparam int AW = ADDRESS_WIDTH - 2;

    logic [1:0]      m_up_wreq;
    logic [2*AW-1:0] m_up_waddr;
    logic [63:0]     m_up_wdata;
    logic [1:0]      m_up_wack;
    logic [1:0]      m_up_rreq;
    logic [2*AW-1:0] m_up_raddr;
    logic [31:0]     m_up_rdata;
    logic [1:0]      m_up_rack;

    logic            s_up_wreq;
    logic [AW-1:0]   s_up_waddr;
    logic [31:0]     s_up_wdata;
    logic            s_up_wack;
    logic            s_up_rreq;
    logic [AW-1:0]   s_up_raddr;
    logic            s_up_rack;
    logic [31:0]     s_up_rdata;

    logic [1:0]      err_timeout;

    modport master (
        input  m_up_wreq, m_up_waddr, m_up_wdata, m_up_rreq, m_up_raddr,
        input  s_up_wack, s_up_rack, s_up_rdata,
        output m_up_wack, m_up_rack, m_up_rdata,
        output s_up_wreq, s_up_waddr, s_up_wdata, s_up_rreq, s_up_raddr,
        output err_timeout
    );

    modport slave (
        output m_up_wreq, m_up_waddr, m_up_wdata, m_up_rreq, m_up_raddr,
        output s_up_wack, s_up_rack, s_up_rdata,
        input  m_up_wack, m_up_rack, m_up_rdata,
        input  s_up_wreq, s_up_waddr, s_up_wdata, s_up_rreq, s_up_raddr,
        input  err_timeout
    );
endinterface

// File: rtl/up_arbiter.sv
// Two-requester arbiter in front of one up register slave. Read and write run as
// independent copies of the same IDLE/ISSUE/WAIT channel with per-requester holding registers.
module up_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         aclk,
    input  logic         arstn,
    up_arbiter_if.master bus
);
    localparam int AW = ADDRESS_WIDTH - 2;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [31:0]   TIMEOUT_RDATA = 32'hDEAD_DEAD;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Channel index 0 = write, 1 = read.
    logic [1:0]    m_req  [2];
    logic [AW-1:0] m_addr [2][2];
    logic          s_ack  [2];
    logic          s_req  [2];
    logic [AW-1:0] s_addr [2];
    logic [1:0]    m_ack  [2];
    logic          err    [2];

    assign m_req[0] = bus.m_up_wreq;
    assign m_req[1] = bus.m_up_rreq;
    assign s_ack[0] = bus.s_up_wack;
    assign s_ack[1] = bus.s_up_rack;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_map
            assign m_addr[0][gi] = bus.m_up_waddr[gi*AW +: AW];
            assign m_addr[1][gi] = bus.m_up_raddr[gi*AW +: AW];
        end

        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [1:0]    state_q, state_d;
            logic [1:0]    pend_q, pend_d;
            logic [1:0]    cap;
            logic          last_q;
            logic          gnt_q, gnt_d;
            logic [CW-1:0] cnt_q;
            logic          s_req_q;
            logic [AW-1:0] s_addr_q;
            logic [1:0]    m_ack_q;
            logic          err_q;
            logic [AW-1:0] hold_q [2];
            logic          start, close_ack, close_to;

            always_comb begin
                cap       = m_req[gi] & ~pend_q;
                start     = 1'b0;
                close_ack = 1'b0;
                close_to  = 1'b0;
                gnt_d     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                state_d   = state_q;
                case (state_q)
                    ST_IDLE: begin
                        if (pend_q != 2'b00) begin
                            start   = 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        state_d = ST_WAIT;
                        if (s_ack[gi]) begin
                            close_ack = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (s_ack[gi]) begin
                            close_ack = 1'b1;
                            state_d   = ST_IDLE;
                        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                            close_to = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
                // cap[g] is always 0 here because pend[g] is held for the whole transaction.
                pend_d = pend_q | cap;
                if (close_ack || close_to) begin
                    pend_d[gnt_q] = 1'b0;
                end
            end

            always_ff @(posedge aclk) begin
                if (!arstn) begin
                    state_q  <= ST_IDLE;
                    pend_q   <= 2'b00;
                    last_q   <= 1'b0;
                    gnt_q    <= 1'b0;
                    cnt_q    <= '0;
                    s_req_q  <= 1'b0;
                    s_addr_q <= '0;
                    m_ack_q  <= 2'b00;
                    err_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    pend_q  <= pend_d;
                    s_req_q <= start;
                    err_q   <= close_to;
                    m_ack_q <= 2'b00;
                    if (start) begin
                        gnt_q    <= gnt_d;
                        last_q   <= gnt_d;
                        s_addr_q <= hold_q[gnt_d];
                    end
                    if (state_q == ST_WAIT) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                    if (close_ack || close_to) begin
                        m_ack_q[gnt_q] <= 1'b1;
                    end
                end
            end

            always_ff @(posedge aclk) begin
                for (int r = 0; r < 2; r++) begin
                    if (cap[r]) begin
                        hold_q[r] <= m_addr[gi][r];
                    end
                end
            end

            assign s_req[gi]  = s_req_q;
            assign s_addr[gi] = s_addr_q;
            assign m_ack[gi]  = m_ack_q;
            assign err[gi]    = err_q;

            if (gi == 0) begin : g_wr
                logic [31:0] wdata_hold_q [2];
                logic [31:0] s_wdata_q;

                always_ff @(posedge aclk) begin
                    for (int r = 0; r < 2; r++) begin
                        if (cap[r]) begin
                            wdata_hold_q[r] <= bus.m_up_wdata[r*32 +: 32];
                        end
                    end
                end

                always_ff @(posedge aclk) begin
                    if (!arstn) begin
                        s_wdata_q <= '0;
                    end else if (start) begin
                        s_wdata_q <= wdata_hold_q[gnt_d];
                    end
                end

                assign bus.s_up_wdata = s_wdata_q;
            end else begin : g_rd
                logic [31:0] rdata_q;

                // Read data only moves on a closing edge, so it is stable outside rack.
                always_ff @(posedge aclk) begin
                    if (!arstn) begin
                        rdata_q <= '0;
                    end else if (close_ack) begin
                        rdata_q <= bus.s_up_rdata;
                    end else if (close_to) begin
                        rdata_q <= TIMEOUT_RDATA;
                    end
                end

                assign bus.m_up_rdata = rdata_q;
            end
        end
    endgenerate

    assign bus.s_up_wreq   = s_req[0];
    assign bus.s_up_waddr  = s_addr[0];
    assign bus.m_up_wack   = m_ack[0];
    assign bus.s_up_rreq   = s_req[1];
    assign bus.s_up_raddr  = s_addr[1];
    assign bus.m_up_rack   = m_ack[1];
    assign bus.err_timeout = {err[1], err[0]};
endmodule

// File: tb/tb_up_arbiter.sv
// Directed bench for up_arbiter: a responsive slave model plus hand-computed expectations
// for latency, tie alternation, concurrency, timeout and mid-transaction reset.
module tb_up_arbiter;
    localparam int ADDRESS_WIDTH  = 32;
    localparam int AW             = ADDRESS_WIDTH - 2;
    localparam int TIMEOUT_CYCLES = 4;

    logic aclk = 1'b0;
    logic arstn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic w_noack   = 1'b0;
    logic r_noack   = 1'b0;
    logic late_rack = 1'b0;
    logic w_armed   = 1'b0;
    logic r_armed   = 1'b0;

    up_arbiter_if #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) bus ();

    up_arbiter #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .aclk (aclk),
        .arstn(arstn),
        .bus  (bus)
    );

    always #5 aclk = ~aclk;

    // Slave: acks one cycle after seeing its request; read data is 0x5000_0000 | address.
    always @(negedge aclk) begin
        bus.s_up_wack  = w_armed;
        bus.s_up_rack  = r_armed | late_rack;
        bus.s_up_rdata = 32'h5000_0000 | 32'(bus.s_up_raddr);
        w_armed        = bus.s_up_wreq & ~w_noack;
        r_armed        = bus.s_up_rreq & ~r_noack;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for an ack on one channel; request pulses are dropped after the first edge.
    task automatic wait_ack(input logic rd, output logic [1:0] ack, output logic [31:0] data,
                            output logic [1:0] err, output int cyc);
        logic [1:0] a;
        ack  = 2'b00;
        data = '0;
        err  = 2'b00;
        cyc  = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                bus.m_up_wreq = 2'b00;
                bus.m_up_rreq = 2'b00;
            end
            a = rd ? bus.m_up_rack : bus.m_up_wack;
            if (a != 2'b00) begin
                ack  = a;
                data = bus.m_up_rdata;
                err  = bus.err_timeout;
                cyc  = k;
                break;
            end
        end
        $display("txn %s ack=%b rdata=%h err=%b after %0d cycles", rd ? "rd" : "wr", ack, data, err, cyc);
    endtask

    initial begin
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [1:0]  acc;
        logic [31:0] data;
        int          cyc;

        arstn          = 1'b0;
        bus.m_up_wreq  = 2'b00;
        bus.m_up_rreq  = 2'b00;
        bus.m_up_waddr = '0;
        bus.m_up_raddr = '0;
        bus.m_up_wdata = '0;
        repeat (3) tick();

        check("rst_wack",  64'(bus.m_up_wack), 64'(0));
        check("rst_rack",  64'(bus.m_up_rack), 64'(0));
        check("rst_rdata", 64'(bus.m_up_rdata), 64'(0));
        check("rst_swreq", 64'(bus.s_up_wreq), 64'(0));
        check("rst_srreq", 64'(bus.s_up_rreq), 64'(0));
        check("rst_swaddr", 64'(bus.s_up_waddr), 64'(0));
        check("rst_swdata", 64'(bus.s_up_wdata), 64'(0));
        check("rst_sraddr", 64'(bus.s_up_raddr), 64'(0));
        check("rst_err",   64'(bus.err_timeout), 64'(0));
        arstn = 1'b1;
        tick();

        // Single write from requester 0
        bus.m_up_waddr[AW-1:0] = AW'(32'h4);
        bus.m_up_wdata[31:0]   = 32'hA5A5_A5A5;
        bus.m_up_wreq          = 2'b01;
        tick();
        bus.m_up_wreq = 2'b00;
        check("wr_sreq_k1", 64'(bus.s_up_wreq), 64'(0));
        tick();
        check("wr_sreq_k2", 64'(bus.s_up_wreq), 64'(1));
        check("wr_saddr",   64'(bus.s_up_waddr), 64'(32'h4));
        check("wr_sdata",   64'(bus.s_up_wdata), 64'(32'hA5A5_A5A5));
        wait_ack(1'b0, ack, data, err, cyc);
        check("wr_lat", 64'(cyc), 64'(2));
        check("wr_ack", 64'(ack), 64'(2'b01));
        tick();
        check("wr_ack_once", 64'(bus.m_up_wack), 64'(0));

        // Read tie right after reset: requester 1 first
        bus.m_up_raddr = {AW'(32'h20), AW'(32'h10)};
        bus.m_up_rreq  = 2'b11;
        wait_ack(1'b1, ack, data, err, cyc);
        check("tie_lat1",  64'(cyc), 64'(4));
        check("tie_ack1",  64'(ack), 64'(2'b10));
        check("tie_data1", 64'(data), 64'(32'h5000_0020));
        wait_ack(1'b1, ack, data, err, cyc);
        check("tie_lat0",  64'(cyc), 64'(3));
        check("tie_ack0",  64'(ack), 64'(2'b01));
        check("tie_data0", 64'(data), 64'(32'h5000_0010));
        tick();
        tick();
        check("rdata_hold", 64'(bus.m_up_rdata), 64'(32'h5000_0010));
        check("rack_idle",  64'(bus.m_up_rack), 64'(0));

        // Three more tie bursts keep alternating 1 then 0
        for (int b = 0; b < 3; b++) begin
            bus.m_up_raddr = {AW'(32'h20 + b), AW'(32'h10 + b)};
            bus.m_up_rreq  = 2'b11;
            wait_ack(1'b1, ack, data, err, cyc);
            check("burst_ack_a",  64'(ack), 64'(2'b10));
            check("burst_data_a", 64'(data), 64'(32'h5000_0020 + b));
            wait_ack(1'b1, ack, data, err, cyc);
            check("burst_ack_b",  64'(ack), 64'(2'b01));
            check("burst_data_b", 64'(data), 64'(32'h5000_0010 + b));
        end

        // Concurrent write (req 0) and read (req 1)
        bus.m_up_waddr[AW-1:0]    = AW'(32'h44);
        bus.m_up_wdata[31:0]      = 32'h1111_2222;
        bus.m_up_raddr[2*AW-1:AW] = AW'(32'h88);
        bus.m_up_wreq             = 2'b01;
        bus.m_up_rreq             = 2'b10;
        tick();
        bus.m_up_wreq = 2'b00;
        bus.m_up_rreq = 2'b00;
        tick();
        check("cc_swreq",  64'(bus.s_up_wreq), 64'(1));
        check("cc_srreq",  64'(bus.s_up_rreq), 64'(1));
        check("cc_sraddr", 64'(bus.s_up_raddr), 64'(32'h88));
        tick();
        tick();
        check("cc_wack",  64'(bus.m_up_wack), 64'(2'b01));
        check("cc_rack",  64'(bus.m_up_rack), 64'(2'b10));
        check("cc_rdata", 64'(bus.m_up_rdata), 64'(32'h5000_0088));

        // Read timeout with a silent slave, then a late ack
        r_noack                   = 1'b1;
        bus.m_up_raddr[2*AW-1:AW] = AW'(32'h30);
        bus.m_up_rreq             = 2'b10;
        wait_ack(1'b1, ack, data, err, cyc);
        check("to_lat",  64'(cyc), 64'(7));
        check("to_ack",  64'(ack), 64'(2'b10));
        check("to_data", 64'(data), 64'(32'hDEAD_DEAD));
        check("to_err",  64'(err), 64'(2'b10));
        tick();
        check("to_err_once", 64'(bus.err_timeout), 64'(0));
        late_rack = 1'b1;
        tick();
        late_rack = 1'b0;
        acc = 2'b00;
        repeat (4) begin
            tick();
            acc |= bus.m_up_rack;
        end
        check("late_no_ack",  64'(acc), 64'(0));
        check("late_rdata",   64'(bus.m_up_rdata), 64'(32'hDEAD_DEAD));
        r_noack = 1'b0;

        // Reset while a write sits in WAIT
        w_noack                   = 1'b1;
        bus.m_up_waddr[2*AW-1:AW] = AW'(32'h8);
        bus.m_up_wdata[63:32]     = 32'h1234_5678;
        bus.m_up_wreq             = 2'b10;
        tick();
        bus.m_up_wreq = 2'b00;
        tick();
        tick();
        check("mid_sdata_held", 64'(bus.s_up_wdata), 64'(32'h1234_5678));
        arstn = 1'b0;
        tick();
        check("mid_swreq",  64'(bus.s_up_wreq), 64'(0));
        check("mid_swaddr", 64'(bus.s_up_waddr), 64'(0));
        check("mid_swdata", 64'(bus.s_up_wdata), 64'(0));
        check("mid_rdata",  64'(bus.m_up_rdata), 64'(0));
        check("mid_wack",   64'(bus.m_up_wack), 64'(0));
        check("mid_err",    64'(bus.err_timeout), 64'(0));
        tick();
        arstn   = 1'b1;
        w_noack = 1'b0;
        acc     = 2'b00;
        repeat (8) begin
            tick();
            acc |= bus.m_up_wack;
        end
        check("mid_no_ack", 64'(acc), 64'(0));

        bus.m_up_waddr[2*AW-1:AW] = AW'(32'hC);
        bus.m_up_wdata[63:32]     = 32'hCAFE_F00D;
        bus.m_up_wreq             = 2'b10;
        tick();
        bus.m_up_wreq = 2'b00;
        tick();
        check("post_swreq",  64'(bus.s_up_wreq), 64'(1));
        check("post_swaddr", 64'(bus.s_up_waddr), 64'(32'hC));
        check("post_swdata", 64'(bus.s_up_wdata), 64'(32'hCAFE_F00D));
        wait_ack(1'b0, ack, data, err, cyc);
        check("post_lat", 64'(cyc), 64'(2));
        check("post_ack", 64'(ack), 64'(2'b10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
